// File: rtl/cpu_bus_ctrl.sv
// CPU-to-narrow-bus bridge: splits byte/half/word requests into BUS_W beats; 4 cycles single beat, +2 per extra beat plus waits.
// Backpressure: o_req_ready only in IDLE, bus waits on i_bus_data_ready, no response stall; BUS_TIMEOUT_EN adds a WAIT abort.
module cpu_bus_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BUS_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_cpu_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [1:0]        i_req_size,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [BUS_W-1:0]  o_bus_data,
  input  logic [BUS_W-1:0]  i_bus_data,
  input  logic              i_bus_data_ready,
  output logic              o_busy
);

  localparam int BEAT_BYTES = BUS_W / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int DATA_BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t            state;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic [2:0]        beats;
  logic [1:0]        beat;
  logic [DATA_W-1:0] acc;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]  tmo_cnt;
`endif

  logic [3:0]        req_bytes;
  logic              req_err;
  logic [2:0]        req_beats;
  logic [1:0]        beat_nxt;
  logic              last;
  logic [ADDR_W-1:0] addr_nxt;
  logic [BUS_W-1:0]  lane_first;
  logic [BUS_W-1:0]  lane_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] rsp_mask;

  always_comb begin
    req_bytes  = 4'd1 << i_req_size;
    req_err    = (i_req_size == 2'd3) || (req_bytes > 4'(DATA_BYTES));
    req_beats  = 3'(req_bytes >> BEAT_SHIFT);
    if (req_beats == 3'd0) req_beats = 3'd1;
    beat_nxt   = beat + 2'd1;
    last       = (({1'b0, beat} + 3'd1) == beats);
    // Sum is truncated to ADDR_W, so a transfer crossing the top of memory wraps to 0.
    addr_nxt   = base + (ADDR_W'(beat_nxt) << BEAT_SHIFT);
    lane_first = BUS_W'(i_req_wdata);
    lane_nxt   = BUS_W'(wdata >> (int'(beat_nxt) * BUS_W));
    acc_nxt    = acc | (DATA_W'(i_bus_data) << (int'(beat) * BUS_W));
    rsp_mask   = '1;
    if (size == 2'd0)      rsp_mask = DATA_W'(8'hFF);
    else if (size == 2'd1) rsp_mask = DATA_W'(16'hFFFF);
  end

  always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_bus_clk   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_data  <= '0;
      o_busy      <= 1'b0;
      we          <= 1'b0;
      base        <= '0;
      wdata       <= '0;
      size        <= '0;
      beats       <= '0;
      beat        <= '0;
      acc         <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            we          <= i_req_we;
            base        <= i_req_addr;
            wdata       <= i_req_wdata;
            size        <= i_req_size;
            beats       <= req_beats;
            beat        <= '0;
            acc         <= '0;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            if (req_err) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else begin
              // Address and data set up a cycle before the strobe rises.
              state      <= ADDR;
              o_bus_addr <= i_req_addr;
              o_bus_we   <= i_req_we;
              o_bus_data <= i_req_we ? lane_first : '0;
            end
          end
        end

        ADDR: begin
          o_bus_clk <= 1'b1;
          state     <= WAIT;
        end

        WAIT: begin
          if (i_bus_data_ready) begin
            o_bus_clk <= 1'b0;
            if (!we) acc <= acc_nxt;
            if (last) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b0;
              o_rsp_rdata <= we ? '0 : (acc_nxt & rsp_mask);
            end else begin
              state      <= ADDR;
              beat       <= beat_nxt;
              o_bus_addr <= addr_nxt;
              o_bus_data <= we ? lane_nxt : '0;
`ifdef BUS_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end else begin
`ifdef BUS_TIMEOUT_EN
            if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
              o_bus_clk   <= 1'b0;
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
`else
            o_bus_clk <= 1'b1;
`endif
          end
        end

        RESP: begin
          o_rsp_valid <= 1'b0;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
